// File: rtl/btc_work_loader_pkg.sv
// Shared widths, job record and assembler states for the mining job loader.
package btc_pkg;

  localparam int WORD_W      = 32;
  localparam int HDR_W       = 608;
  localparam int N_HDR_WORDS = HDR_W / WORD_W;
  localparam int TGT_W       = 8;

  // One complete mining job as handed to the core.
  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [TGT_W-1:0] tgt;
  } btc_job_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    TARGET  = 2'd1,
    DRAIN   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/btc_work_loader_fifo.sv
// Small job queue between the word assembler and the miner core.
// Full/empty come from registered pointers carrying one extra wrap bit.
module btc_job_fifo
  import btc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btc_job_t push_job,
  input  logic     pop,
  input  logic     flush,
  output btc_job_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  btc_job_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush drops every queued job at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is reset so the core never sees X on the job outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_job;
    end
  end

endmodule

// File: rtl/btc_work_loader.sv
// Assembles 20-word mining jobs from the host word stream, queues them and
// presents the head job to the miner core.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_val/in_rdy, in_rdy never depends on in_val.
// Core side: req_val/req_rdy, req_val and the job stay stable until taken.
module btc_work_loader
  import btc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_val,
  input  logic              in_last,
  output logic              in_rdy,
  input  logic              flush,
  output logic [HDR_W-1:0]  block_header,
  output logic [TGT_W-1:0]  hash_target,
  output logic              req_val,
  input  logic              req_rdy,
  output logic [31:0]       jobs_issued,
  output logic              err_sticky,
  input  logic              err_clr,
  output ld_state_e         dbg_state
);

  localparam logic [4:0] LAST_HDR_IDX = 5'(N_HDR_WORDS - 1);

  ld_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [HDR_W-1:0] hdr_q;
  logic        live_q;
  logic        acc;
  logic        push;
  logic        err_set;
  logic        fifo_full;
  logic        fifo_empty;
  logic        issue;
  btc_job_t    push_job;
  btc_job_t    head_job;

  // Ready depends only on registered state; TARGET waits for queue room.
  assign in_rdy   = live_q && ((state_q != TARGET) || !fifo_full);
  assign acc      = in_val && in_rdy;
  assign req_val  = !fifo_empty;
  assign issue    = req_val && req_rdy;
  assign push_job = '{hdr: hdr_q, tgt: in_data[TGT_W-1:0]};
  assign block_header = head_job.hdr;
  assign hash_target  = head_job.tgt;
  assign dbg_state    = state_q;

  // Holds in_rdy low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Assembler state and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: framing checks, push on a well-formed final word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    err_set = 1'b0;
    case (state_q)
      COLLECT: begin
        if (acc) begin
          if (in_last) begin
            // Job ended before its header was complete.
            err_set = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == LAST_HDR_IDX) begin
            state_d = TARGET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      TARGET: begin
        if (acc) begin
          if (in_last) begin
            push    = 1'b1;
            state_d = COLLECT;
          end else begin
            // Job runs past 20 words: drop it and skip to its last word.
            err_set = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (acc && in_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
      push    = 1'b0;
      err_set = 1'b0;
    end
  end

  // Header words shift in MSB-first; 19 words fully replace the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q <= '0;
    end else if (acc && !flush && (state_q == COLLECT)) begin
      hdr_q <= {hdr_q[HDR_W-WORD_W-1:0], in_data};
    end
  end

  // Sticky framing error; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (err_clr) err_sticky <= 1'b0;
  end

  // Count core handshakes, including one coinciding with flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     jobs_issued <= '0;
    else if (issue) jobs_issued <= jobs_issued + 32'd1;
  end

  btc_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_job (push_job),
    .pop      (issue),
    .flush    (flush),
    .head     (head_job),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_btc_work_loader.sv
// Directed bench for btc_work_loader with a scoreboard of expected jobs.
module tb_btc_work_loader;
  import btc_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [WORD_W-1:0] in_data;
  logic              in_val;
  logic              in_last;
  logic              in_rdy;
  logic              flush;
  logic [HDR_W-1:0]  block_header;
  logic [TGT_W-1:0]  hash_target;
  logic              req_val;
  logic              req_rdy;
  logic [31:0]       jobs_issued;
  logic              err_sticky;
  logic              err_clr;
  ld_state_e         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [HDR_W+TGT_W-1:0] exp_q[$];

  btc_work_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_val       (in_val),
    .in_last      (in_last),
    .in_rdy       (in_rdy),
    .flush        (flush),
    .block_header (block_header),
    .hash_target  (hash_target),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .jobs_issued  (jobs_issued),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [HDR_W+TGT_W-1:0] obs,
                       input logic [HDR_W+TGT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every core handshake must match the oldest expected job.
  always @(negedge clk) begin
    if (rst_n && req_val && req_rdy) begin
      if (exp_q.size() == 0) check("issue_unexpected", exp_q.size(), 1);
      else check("issue", {block_header, hash_target}, exp_q.pop_front());
    end
  end

  // Drivers
  task automatic wait_accept(input string tag);
    int   n  = 0;
    logic ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] data, input logic last);
    in_data = data;
    in_val  = 1'b1;
    in_last = last;
    wait_accept("send_word");
  endtask

  task automatic send_hdr(input logic [HDR_W-1:0] h, input int nwords);
    for (int k = 0; k < nwords; k++) send_word(h[HDR_W-1-WORD_W*k -: WORD_W], 1'b0);
  endtask

  function automatic logic [HDR_W-1:0] rand_hdr();
    logic [HDR_W-1:0] h;
    for (int i = 0; i < N_HDR_WORDS; i++) h[i*WORD_W +: WORD_W] = $urandom();
    return h;
  endfunction

  // Well-formed job; the expectation is queued as it is driven.
  task automatic send_job(input logic [HDR_W-1:0] h, input logic [TGT_W-1:0] tgt);
    logic [WORD_W-1:0] w;
    send_hdr(h, N_HDR_WORDS);
    exp_q.push_back({h, tgt});
    w = $urandom();
    w[TGT_W-1:0] = tgt;
    send_word(w, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int   n    = 0;
    logic done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      done = !req_val && (exp_q.size() == 0);
      n++;
    end
    if (!done) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  logic [HDR_W-1:0]  h;
  logic [WORD_W-1:0] w;

  initial begin
    // Reset
    rst_n = 1'b0; in_data = '0; in_val = 1'b0; in_last = 1'b0;
    flush = 1'b0; req_rdy = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_req_val", req_val, 0);
    check("rst_header", block_header, 0);
    check("rst_target", hash_target, 0);
    check("rst_jobs", jobs_issued, 0);
    check("rst_err", err_sticky, 0);
    check("rst_state", dbg_state, COLLECT);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_rdy_after", in_rdy, 1);

    // 1: single fixed job, latency and contents
    h = {32'h0100_0000, 576'b0};
    send_hdr(h, N_HDR_WORDS);
    check("t1_no_early_req", req_val, 0);
    exp_q.push_back({h, 8'h04});
    send_word(32'h0000_0004, 1'b1);
    check("t1_req_latency", req_val, 1);
    check("t1_hdr_top", block_header[607:576], 32'h0100_0000);
    check("t1_hdr_rest", block_header[575:0], 0);
    check("t1_target", hash_target, 8'h04);
    req_rdy = 1'b1;
    @(posedge clk);
    #1;
    req_rdy = 1'b0;
    check("t1_req_drop", req_val, 0);
    check("t1_jobs", jobs_issued, 1);

    // 2: three jobs while the core stalls; third stalls at word 19
    send_job(rand_hdr(), 8'd4);
    send_job(rand_hdr(), 8'd8);
    check("t2_req_val", req_val, 1);
    h = rand_hdr();
    send_hdr(h, N_HDR_WORDS);
    exp_q.push_back({h, 8'd12});
    in_data = {24'hA5A5A5, 8'd12};
    in_val = 1'b1;
    in_last = 1'b1;
    @(negedge clk);
    check("t2_stall_in_rdy", in_rdy, 0);
    @(posedge clk);
    #1;
    req_rdy = 1'b1;
    wait_accept("t2_w19");
    wait_idle("t2");
    check("t2_jobs", jobs_issued, 4);

    // 3: premature last on word 5
    send_hdr(rand_hdr(), 5);
    send_word($urandom(), 1'b1);
    check("t3_err", err_sticky, 1);
    check("t3_no_push", req_val, 0);
    check("t3_state", dbg_state, COLLECT);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t3_err_clr", err_sticky, 0);
    send_job(rand_hdr(), 8'h5A);
    wait_idle("t3");
    check("t3_jobs", jobs_issued, 5);

    // 4: 21-word job is dropped and drained
    send_hdr(rand_hdr(), N_HDR_WORDS);
    send_word($urandom(), 1'b0);
    check("t4_err", err_sticky, 1);
    check("t4_drain_state", dbg_state, DRAIN);
    send_word($urandom(), 1'b1);
    check("t4_back_collect", dbg_state, COLLECT);
    check("t4_no_push", req_val, 0);
    send_job(rand_hdr(), 8'hC3);
    wait_idle("t4");
    check("t4_jobs", jobs_issued, 6);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t4_err_clr", err_sticky, 0);
    // clear and new error together: set wins
    err_clr = 1'b1;
    send_word($urandom(), 1'b1);
    err_clr = 1'b0;
    check("t4_set_wins", err_sticky, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("t4_err_clr2", err_sticky, 0);

    // 5: flush with two queued jobs and a same-cycle handshake and word
    req_rdy = 1'b0;
    send_job(rand_hdr(), 8'h11);
    send_job(rand_hdr(), 8'h22);
    check("t5_req_val", req_val, 1);
    req_rdy = 1'b1;
    flush   = 1'b1;
    in_data = $urandom();
    in_val  = 1'b1;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    in_val = 1'b0;
    req_rdy = 1'b0;
    exp_q.delete();
    check("t5_req_val_flushed", req_val, 0);
    check("t5_jobs", jobs_issued, 7);
    check("t5_state", dbg_state, COLLECT);
    req_rdy = 1'b1;
    send_job(rand_hdr(), 8'h33);
    wait_idle("t5");
    check("t5_jobs_after", jobs_issued, 8);
    check("t5_no_err", err_sticky, 0);

    // 6: async reset in the middle of a header
    send_word($urandom(), 1'b1);
    check("t6_err_before", err_sticky, 1);
    req_rdy = 1'b0;
    send_job(rand_hdr(), 8'h44);
    send_hdr(rand_hdr(), 10);
    in_data = $urandom();
    in_val  = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t6_in_rdy", in_rdy, 0);
    check("t6_req_val", req_val, 0);
    check("t6_header", block_header, 0);
    check("t6_target", hash_target, 0);
    check("t6_jobs", jobs_issued, 0);
    check("t6_err", err_sticky, 0);
    check("t6_state", dbg_state, COLLECT);
    in_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_in_rdy_after", in_rdy, 1);
    req_rdy = 1'b1;
    send_job(rand_hdr(), 8'h77);
    wait_idle("t6");
    check("t6_jobs_after", jobs_issued, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
